gzip_stream_checker: RTL and testbench

GZIP_STREAM_CHECKER -- requirements
Module: gzip_stream_checker

---
 rtl/gzip_stream_checker_if.sv | 38 +++
 rtl/gzip_stream_checker.sv | 206 ++++++++++++++++++++
 tb/tb_gzip_stream_checker.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gzip_stream_checker_if.sv
// Stream and report bundle for the gzip stream checker.
// The slave modport is the checker itself, the master modport is whoever
// feeds gzip words in, takes the byte stream out and reads the report.
interface gzip_stream_checker_if;
    logic        i_tready;
    logic        i_tvalid;
    logic [31:0] i_tdata;
    logic [3:0]  i_tkeep;
    logic        i_tlast;

    logic        o_tready;
    logic        o_tvalid;
    logic [7:0]  o_tdata;
    logic        o_tlast;

    logic        o_done;
    logic        o_hdr_ok;
    logic        o_short;
    logic [31:0] o_len;
    logic [31:0] o_crc;
    logic [31:0] o_isize;

    modport slave (
        output i_tready,
        input  i_tvalid, i_tdata, i_tkeep, i_tlast,
        input  o_tready,
        output o_tvalid, o_tdata, o_tlast,
        output o_done, o_hdr_ok, o_short, o_len, o_crc, o_isize
    );

    modport master (
        input  i_tready,
        output i_tvalid, i_tdata, i_tkeep, i_tlast,
        output o_tready,
        input  o_tvalid, o_tdata, o_tlast,
        input  o_done, o_hdr_ok, o_short, o_len, o_crc, o_isize
    );
endinterface

// File: rtl/gzip_stream_checker.sv
// gzip_stream_checker: takes 32-bit gzip words with byte keeps, re-emits
// the kept bytes one at a time and produces a per-packet report (length,
// gzip magic/method check, CRC32 and ISIZE trailer fields).
module gzip_stream_checker (
    input  logic clk,
    input  logic rstn,
    gzip_stream_checker_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        EMIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] buf_data;
    logic [3:0]  buf_keep;
    logic        buf_last;
    logic        in_ready;

    logic        accept;
    logic        out_valid;
    logic        out_last;
    logic        out_hs;
    logic        pkt_end;

    logic [1:0]  sel;
    logic [3:0]  sel_mask;
    logic [3:0]  rem_after;
    logic [7:0]  cur_byte;
    logic [7:0]  hdr_byte;

    logic [31:0] len_cnt;
    logic [31:0] len_next;
    logic        hdr_fail;
    logic        hdr_fail_next;
    logic [63:0] tail_reg;
    logic [63:0] tail_next;

    logic        done_q;
    logic        hdr_ok_q;
    logic        short_q;
    logic [31:0] len_q;
    logic [31:0] crc_q;
    logic [31:0] isize_q;

    assign accept  = bus.i_tvalid && in_ready;
    assign out_hs  = out_valid && bus.o_tready;
    assign pkt_end = (out_hs && out_last) || ((state == DRAIN) && buf_last);

    assign bus.i_tready = in_ready;
    assign bus.o_tvalid = out_valid;
    assign bus.o_tdata  = out_valid ? cur_byte : 8'h00;
    assign bus.o_tlast  = out_last;
    assign bus.o_done   = done_q;
    assign bus.o_hdr_ok = hdr_ok_q;
    assign bus.o_short  = short_q;
    assign bus.o_len    = len_q;
    assign bus.o_crc    = crc_q;
    assign bus.o_isize  = isize_q;

    // Pick the lowest byte still pending in the buffer; buf_keep is the
    // set of kept bytes not yet handed out, so emission is ascending.
    always_comb begin
        sel      = 2'd0;
        sel_mask = 4'b0001;
        cur_byte = 8'h00;
        if (buf_keep[0]) begin
            sel      = 2'd0;
            sel_mask = 4'b0001;
        end else if (buf_keep[1]) begin
            sel      = 2'd1;
            sel_mask = 4'b0010;
        end else if (buf_keep[2]) begin
            sel      = 2'd2;
            sel_mask = 4'b0100;
        end else if (buf_keep[3]) begin
            sel      = 2'd3;
            sel_mask = 4'b1000;
        end
        rem_after = buf_keep & ~sel_mask;
        case (sel)
            2'd0:    cur_byte = buf_data[7:0];
            2'd1:    cur_byte = buf_data[15:8];
            2'd2:    cur_byte = buf_data[23:16];
            default: cur_byte = buf_data[31:24];
        endcase
    end

    // Next-state and stream outputs: a word with no kept bytes takes a
    // single DRAIN cycle, otherwise EMIT lasts until the last kept byte
    // has been accepted downstream.
    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = (bus.i_tkeep == 4'b0000) ? DRAIN : EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_last  = buf_last && (rem_after == 4'b0000);
                if (bus.o_tready && (rem_after == 4'b0000)) begin
                    state_next = EMPTY;
                end
            end
            DRAIN: begin
                state_next = EMPTY;
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Running packet statistics including the byte being handed out now,
    // so the report can be latched on the same edge as the final byte.
    always_comb begin
        hdr_byte = 8'h00;
        case (len_cnt[1:0])
            2'd0:    hdr_byte = 8'h1F;
            2'd1:    hdr_byte = 8'h8B;
            2'd2:    hdr_byte = 8'h08;
            default: hdr_byte = 8'h00;
        endcase
        len_next      = len_cnt;
        hdr_fail_next = hdr_fail;
        tail_next     = tail_reg;
        if (out_hs) begin
            if (len_cnt != 32'hFFFF_FFFF) begin
                len_next = len_cnt + 32'd1;
            end
            if ((len_cnt < 32'd3) && (cur_byte != hdr_byte)) begin
                hdr_fail_next = 1'b1;
            end
            tail_next = {cur_byte, tail_reg[63:8]};
        end
    end

    // State register; in_ready follows the buffer becoming free so that it
    // never depends combinationally on o_tready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == EMPTY);
        end
    end

    // Word buffer: loaded on acceptance, pending-byte mask shrinks by one
    // byte on every downstream handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_data <= 32'h0;
            buf_keep <= 4'h0;
            buf_last <= 1'b0;
        end else if (accept) begin
            buf_data <= bus.i_tdata;
            buf_keep <= bus.i_tkeep;
            buf_last <= bus.i_tlast;
        end else if (out_hs) begin
            buf_keep <= rem_after;
        end
    end

    // Packet statistics and report: on packet end the report is latched and
    // the statistics restart from zero for the next packet.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_cnt  <= 32'h0;
            hdr_fail <= 1'b0;
            tail_reg <= 64'h0;
            done_q   <= 1'b0;
            hdr_ok_q <= 1'b0;
            short_q  <= 1'b0;
            len_q    <= 32'h0;
            crc_q    <= 32'h0;
            isize_q  <= 32'h0;
        end else begin
            done_q <= pkt_end;
            if (pkt_end) begin
                len_cnt  <= 32'h0;
                hdr_fail <= 1'b0;
                tail_reg <= 64'h0;
                len_q    <= len_next;
                hdr_ok_q <= !hdr_fail_next && (len_next >= 32'd3);
                short_q  <= (len_next < 32'd18);
                crc_q    <= tail_next[31:0];
                isize_q  <= tail_next[63:32];
            end else begin
                len_cnt  <= len_next;
                hdr_fail <= hdr_fail_next;
                tail_reg <= tail_next;
            end
        end
    end

endmodule

// File: tb/tb_gzip_stream_checker.sv
// Testbench for gzip_stream_checker: directed packet table, hand-written
// corner sequences and random packets under backpressure, all checked
// against a byte-list model of the packet.
module tb_gzip_stream_checker;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    typedef struct packed {
        logic [7:0] b;
        logic       l;
    } ebyte_t;

    typedef struct packed {
        logic [31:0] len;
        logic        hdr;
        logic        sh;
        logic [31:0] crc;
        logic [31:0] isize;
    } rep_t;

    typedef struct packed {
        logic [191:0] bytes;
        logic [7:0]   n;
        rep_t         exp;
    } vec_t;

    localparam logic [79:0] HDR_OK  = 80'h03000000000000088B1F;
    localparam logic [79:0] HDR_BAD = 80'h03000000000000088B1E;

    logic clk;
    logic rstn;

    gzip_stream_checker_if bus ();

    gzip_stream_checker dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int     total;
    int     bad;
    int     taken;
    int     popped;
    logic   stall;
    logic   gaps;

    word_t  pkt[$];
    word_t  in_q[$];
    ebyte_t exp_b[$];
    rep_t   exp_r[$];
    vec_t   vecs[7];

    logic        prev_acc;
    logic [3:0]  prev_keep;
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic        prev_last;
    logic        prev_done;
    ebyte_t      mon_e;
    rep_t        mon_r;
    rep_t        mdl;
    logic [31:0] rd;
    logic [3:0]  rk;
    int          nw;
    int          t0;
    int          t1;
    int          cnt;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got no end of test, expected end before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input string what);
        total++;
        bad++;
        $display("[TB] FAIL %s: got %s, expected none", name, what);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_i_tready"}, 32'(bus.i_tready), 32'h0);
        check_output({tag, "_o_tvalid"}, 32'(bus.o_tvalid), 32'h0);
        check_output({tag, "_o_tlast"},  32'(bus.o_tlast),  32'h0);
        check_output({tag, "_o_tdata"},  32'(bus.o_tdata),  32'h0);
        check_output({tag, "_o_done"},   32'(bus.o_done),   32'h0);
        check_output({tag, "_o_hdr_ok"}, 32'(bus.o_hdr_ok), 32'h0);
        check_output({tag, "_o_short"},  32'(bus.o_short),  32'h0);
        check_output({tag, "_o_len"},    bus.o_len,         32'h0);
        check_output({tag, "_o_crc"},    bus.o_crc,         32'h0);
        check_output({tag, "_o_isize"},  bus.o_isize,       32'h0);
    endtask

    task automatic add_word(input logic [31:0] d, input logic [3:0] k);
        pkt.push_back('{d: d, k: k, l: 1'b0});
    endtask

    // Reference model: flatten the packet into its kept bytes, then derive
    // the expected byte stream and the report straight from that list.
    task automatic commit_packet(output rep_t r);
        logic [7:0] bl[$];
        int         n;
        int         idx;
        int         hk;
        int         lastw;
        word_t      w;
        lastw = pkt.size() - 1;
        for (int wi = 0; wi <= lastw; wi++) begin
            w = pkt[wi];
            w.l = (wi == lastw);
            hk = -1;
            for (int k = 0; k < 4; k++) begin
                if (w.k[k]) hk = k;
            end
            for (int k = 0; k < 4; k++) begin
                if (w.k[k]) begin
                    bl.push_back(w.d[8*k +: 8]);
                    exp_b.push_back('{b: w.d[8*k +: 8], l: (wi == lastw) && (k == hk)});
                end
            end
            in_q.push_back(w);
        end
        n = bl.size();
        r.len = 32'(n);
        r.sh  = (n < 18);
        r.hdr = 1'b0;
        if (n >= 3) r.hdr = (bl[0] == 8'h1F) && (bl[1] == 8'h8B) && (bl[2] == 8'h08);
        r.crc   = 32'h0;
        r.isize = 32'h0;
        for (int i = 0; i < 4; i++) begin
            idx = n - 8 + i;
            if (idx >= 0) r.crc[8*i +: 8] = bl[idx];
            idx = n - 4 + i;
            if (idx >= 0) r.isize[8*i +: 8] = bl[idx];
        end
        pkt.delete();
    endtask

    task automatic apply_stimulus(input vec_t v);
        int   words;
        logic [3:0] kk;
        rep_t unused_r;
        words = (int'(v.n) + 3) / 4;
        for (int w = 0; w < words; w++) begin
            for (int k = 0; k < 4; k++) kk[k] = ((4 * w + k) < int'(v.n));
            add_word(v.bytes[32*w +: 32], kk);
        end
        commit_packet(unused_r);
        exp_r.push_back(v.exp);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((in_q.size() > 0 || exp_b.size() > 0 || exp_r.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            fail_event("wait_idle_timeout", $sformatf("%0d bytes and %0d reports pending", exp_b.size(), exp_r.size()));
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0; taken = 0; popped = 0;
        stall = 1'b0; gaps = 1'b0;
        prev_acc = 1'b0; prev_keep = 4'h0; prev_stall = 1'b0;
        prev_data = 8'h00; prev_last = 1'b0; prev_done = 1'b0;
        bus.i_tvalid = 1'b0; bus.i_tdata = 32'h0; bus.i_tkeep = 4'h0;
        bus.i_tlast = 1'b0; bus.o_tready = 1'b1;
        rstn = 1'b0;

        vecs[0] = '{bytes: {112'h0, HDR_OK}, n: 8'd18,
                    exp: '{len: 32'd18, hdr: 1'b1, sh: 1'b0, crc: 32'h0, isize: 32'h0}};
        vecs[1] = '{bytes: {48'h0, 64'h0000000512345678, HDR_OK}, n: 8'd18,
                    exp: '{len: 32'd18, hdr: 1'b1, sh: 1'b0, crc: 32'h12345678, isize: 32'h5}};
        vecs[2] = '{bytes: {112'h0, HDR_BAD}, n: 8'd18,
                    exp: '{len: 32'd18, hdr: 1'b0, sh: 1'b0, crc: 32'h0, isize: 32'h0}};
        vecs[3] = '{bytes: {112'h0, HDR_OK}, n: 8'd10,
                    exp: '{len: 32'd10, hdr: 1'b1, sh: 1'b1, crc: 32'h00000008, isize: 32'h03000000}};
        vecs[4] = '{bytes: {112'h0, HDR_OK}, n: 8'd2,
                    exp: '{len: 32'd2, hdr: 1'b0, sh: 1'b1, crc: 32'h0, isize: 32'h8B1F0000}};
        vecs[5] = '{bytes: {32'h0, 64'h44332211DDCCBBAA, 16'hFFEE, HDR_OK}, n: 8'd20,
                    exp: '{len: 32'd20, hdr: 1'b1, sh: 1'b0, crc: 32'hDDCCBBAA, isize: 32'h44332211}};
        vecs[6] = '{bytes: {112'h0, HDR_OK}, n: 8'd1,
                    exp: '{len: 32'd1, hdr: 1'b0, sh: 1'b1, crc: 32'h0, isize: 32'h1F000000}};

        fork
            // Input driver: holds a word until it is taken, optional gaps,
            // random downstream ready when stalling is enabled.
            begin
                forever begin
                    @(posedge clk);
                    #1;
                    if (!rstn) begin
                        bus.i_tvalid = 1'b0;
                        in_q.delete();
                        popped = taken;
                    end else begin
                        if (popped != taken) begin
                            popped = taken;
                            void'(in_q.pop_front());
                            bus.i_tvalid = 1'b0;
                        end
                        if (!bus.i_tvalid && in_q.size() > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
                            bus.i_tvalid = 1'b1;
                            bus.i_tdata  = in_q[0].d;
                            bus.i_tkeep  = in_q[0].k;
                            bus.i_tlast  = in_q[0].l;
                        end
                        bus.o_tready = stall ? ($urandom_range(0, 9) < 6) : 1'b1;
                    end
                end
            end
            // Output monitor sampled on the falling edge
            begin
                forever begin
                    @(negedge clk);
                    if (!rstn) begin
                        prev_acc = 1'b0; prev_stall = 1'b0; prev_done = 1'b0;
                    end else begin
                        if (prev_acc) check_output("first_byte_latency", 32'(bus.o_tvalid), 32'(prev_keep != 4'h0));
                        if (prev_stall) begin
                            check_output("stall_valid", 32'(bus.o_tvalid), 32'h1);
                            check_output("stall_data", 32'(bus.o_tdata), 32'(prev_data));
                            check_output("stall_last", 32'(bus.o_tlast), 32'(prev_last));
                        end
                        if (bus.o_tvalid) check_output("ready_while_full", 32'(bus.i_tready), 32'h0);
                        if (bus.o_tvalid && bus.o_tready) begin
                            if (exp_b.size() == 0) begin
                                fail_event("extra_byte", $sformatf("byte 0x%0h", bus.o_tdata));
                            end else begin
                                mon_e = exp_b.pop_front();
                                check_output("byte_data", 32'(bus.o_tdata), 32'(mon_e.b));
                                check_output("byte_last", 32'(bus.o_tlast), 32'(mon_e.l));
                            end
                        end
                        if (bus.o_done) begin
                            if (prev_done) fail_event("done_width", "o_done high two cycles");
                            if (exp_r.size() == 0) begin
                                fail_event("unexpected_done", $sformatf("o_done with len %0d", bus.o_len));
                            end else begin
                                mon_r = exp_r.pop_front();
                                check_output("rep_len", bus.o_len, mon_r.len);
                                check_output("rep_hdr_ok", 32'(bus.o_hdr_ok), 32'(mon_r.hdr));
                                check_output("rep_short", 32'(bus.o_short), 32'(mon_r.sh));
                                check_output("rep_crc", bus.o_crc, mon_r.crc);
                                check_output("rep_isize", bus.o_isize, mon_r.isize);
                            end
                        end
                        prev_done  = bus.o_done;
                        prev_acc   = bus.i_tvalid && bus.i_tready;
                        prev_keep  = bus.i_tkeep;
                        if (prev_acc) taken++;
                        prev_stall = bus.o_tvalid && !bus.o_tready;
                        prev_data  = bus.o_tdata;
                        prev_last  = bus.o_tlast;
                    end
                end
            end
        join_none

        // Reset state and release
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;
        #1 check_output("ready_before_first_edge", 32'(bus.i_tready), 32'h0);
        @(posedge clk);
        #1 check_output("ready_after_first_edge", 32'(bus.i_tready), 32'h1);

        // Directed packet table, clean and then under stalls and gaps
        for (int pass = 0; pass < 2; pass++) begin
            stall = (pass == 1);
            gaps  = (pass == 1);
            for (int v = 0; v < 7; v++) apply_stimulus(vecs[v]);
            wait_idle(4000);
        end

        // Sustained rate: three full words, first to last byte spans 13 cycles
        stall = 1'b0;
        gaps  = 1'b0;
        for (int w = 0; w < 3; w++) add_word($urandom, 4'hF);
        commit_packet(mdl);
        exp_r.push_back(mdl);
        t0 = -1; t1 = -1; cnt = 0;
        while (cnt < 300 && t1 < 0) begin
            @(negedge clk);
            cnt++;
            if (bus.o_tvalid && bus.o_tready) begin
                if (t0 < 0) t0 = cnt;
                if (bus.o_tlast) t1 = cnt;
            end
        end
        check_output("throughput_span", 32'(t1 - t0), 32'd13);
        wait_idle(500);

        // Sparse keep: only bytes 1 and 3 leave, 0xBB then 0xDD
        add_word(32'hDDCCBBAA, 4'b1010);
        commit_packet(mdl);
        exp_r.push_back('{len: 32'd2, hdr: 1'b0, sh: 1'b1, crc: 32'h0, isize: 32'hDDBB0000});
        wait_idle(500);

        // Empty last word: packet ends without an o_tlast byte
        add_word(32'h00088B1F, 4'hF);
        add_word(32'h12345678, 4'h0);
        commit_packet(mdl);
        exp_r.push_back('{len: 32'd4, hdr: 1'b1, sh: 1'b1, crc: 32'h0, isize: 32'h00088B1F});
        wait_idle(500);

        // Random packets under backpressure and input gaps
        stall = 1'b1;
        gaps  = 1'b1;
        for (int p = 0; p < 30; p++) begin
            nw = $urandom_range(1, 8);
            for (int w = 0; w < nw; w++) begin
                rd = $urandom;
                rk = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
                if (w == 0 && (p % 2) == 0) begin
                    rd = {rd[31:24], 24'h088B1F};
                    rk = 4'hF;
                end
                add_word(rd, rk);
            end
            commit_packet(mdl);
            exp_r.push_back(mdl);
        end
        wait_idle(20000);

        // Reset in the middle of a packet: outputs clear at once, no report
        for (int w = 0; w < 6; w++) add_word($urandom, 4'hF);
        commit_packet(mdl);
        exp_r.push_back(mdl);
        repeat (10) @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_reset_outputs("mid_reset");
        exp_b.delete();
        exp_r.delete();
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;
        repeat (4) @(negedge clk);
        stall = 1'b0;
        gaps  = 1'b0;
        apply_stimulus(vecs[1]);
        wait_idle(1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
